// File: rtl/ext_unit_pkg.sv
// Shared definitions for the external unit (AR/AW/R buffers).
// Latency: n/a (constants and helpers only).
// Backpressure: n/a.
// Holds the AXI response encodings, the burst-length constants used by the AR/AW
// buffers and a helper that classifies error responses.
package ext_unit_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // AXI4 burst length: an 8-bit AxLEN field encoding 1..256 beats.
  localparam int AXI_LEN_WIDTH     = 8;
  localparam int AXI_MAX_BURST_LEN = 256;

  // SLVERR and DECERR are the only encodings with bit 1 set.
  function automatic logic is_err_resp(input logic [1:0] resp);
    return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
  endfunction

endpackage

// File: rtl/ext_fifo_ctrl.sv
// FIFO bookkeeping: write/read pointers, occupancy count and full/empty flags.
// Latency: all state updates on the clock edge after i_push/i_pop.
// Backpressure: the caller must qualify i_push with ~o_full and i_pop with ~o_empty.
// Ports: i_clk, i_rst (sync, active-high), i_push, i_pop -> o_wr_ptr, o_rd_ptr,
//        o_count, o_full, o_empty. DEPTH must be a power of two, >= 2.
module ext_fifo_ctrl
  import ext_unit_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic             i_pop,
  output logic [PTR_W-1:0] o_wr_ptr,
  output logic [PTR_W-1:0] o_rd_ptr,
  output logic [CNT_W-1:0] o_count,
  output logic             o_full,
  output logic             o_empty
);

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  // Pointers are exactly log2(DEPTH) bits wide, so the increment wraps
  // DEPTH-1 -> 0 without extra logic.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_wr_ptr = r_wr_ptr;
  assign o_rd_ptr = r_rd_ptr;
  assign o_count  = r_count;
  assign o_full   = (r_count == CNT_W'(DEPTH));
  assign o_empty  = (r_count == '0);

endmodule

// File: rtl/ext_r_buffer.sv
// Elastic buffer on the AXI R channel, external bus -> DMA engine, with sticky error flag.
// Latency: 1 cycle minimum; 0 cycles when empty if EXT_R_BUFFER_BYPASS_EN is defined.
// Backpressure: slave_ready_o = not full, from registered state only (no path from master_ready_i).
// Ports: clk_i, rst_i (sync, active-high); slave_* R beat in; master_* R beat out;
//        count_o occupancy; resp_err_o sticky SLVERR/DECERR seen.
// Optional: define EXT_R_BUFFER_BYPASS_EN for the empty-buffer combinational bypass.
module ext_r_buffer
  import ext_unit_pkg::*;
#(
  parameter int ID_WIDTH   = 4,
  parameter int DATA_WIDTH = 64,
  parameter int USER_WIDTH = 6,
  parameter int DEPTH      = 4,
  localparam int CNT_WIDTH = $clog2(DEPTH + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  slave_valid_i,
  input  logic [DATA_WIDTH-1:0] slave_data_i,
  input  logic [1:0]            slave_resp_i,
  input  logic                  slave_last_i,
  input  logic [ID_WIDTH-1:0]   slave_id_i,
  input  logic [USER_WIDTH-1:0] slave_user_i,
  output logic                  slave_ready_o,
  output logic                  master_valid_o,
  output logic [DATA_WIDTH-1:0] master_data_o,
  output logic [1:0]            master_resp_o,
  output logic                  master_last_o,
  output logic [ID_WIDTH-1:0]   master_id_o,
  output logic [USER_WIDTH-1:0] master_user_o,
  input  logic                  master_ready_i,
  output logic [CNT_WIDTH-1:0]  count_o,
  output logic                  resp_err_o
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int BEAT_W = DATA_WIDTH + 2 + 1 + USER_WIDTH + ID_WIDTH;

  logic [BEAT_W-1:0] r_mem [DEPTH];
  logic              r_resp_err;

  logic [PTR_W-1:0]  w_wr_ptr;
  logic [PTR_W-1:0]  w_rd_ptr;
  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_wr_en;
  logic              w_pop;
  logic [BEAT_W-1:0] w_in_beat;
  logic [BEAT_W-1:0] w_out_beat;
  logic [BEAT_W-1:0] w_out_masked;

  assign w_in_beat = {slave_data_i, slave_resp_i, slave_last_i, slave_user_i, slave_id_i};

  assign slave_ready_o = ~w_full & ~rst_i;
  assign w_push        = slave_valid_i & slave_ready_o;
  // Only stored beats are popped from the FIFO; a bypassed beat never enters it.
  assign w_pop         = ~w_empty & ~rst_i & master_ready_i;

`ifdef EXT_R_BUFFER_BYPASS_EN
  logic w_bypass;
  // An empty buffer forwards the incoming beat straight through; it is written
  // only if the DMA does not take it this cycle.
  assign w_bypass       = w_empty & slave_valid_i & ~rst_i;
  assign master_valid_o = (~w_empty & ~rst_i) | w_bypass;
  assign w_out_beat     = w_empty ? w_in_beat : r_mem[w_rd_ptr];
  assign w_wr_en        = w_push & ~(w_bypass & master_ready_i);
`else
  assign master_valid_o = ~w_empty & ~rst_i;
  assign w_out_beat     = r_mem[w_rd_ptr];
  assign w_wr_en        = w_push;
`endif

  ext_fifo_ctrl #(
    .DEPTH (DEPTH)
  ) u_ctrl (
    .i_clk    (clk_i),
    .i_rst    (rst_i),
    .i_push   (w_wr_en),
    .i_pop    (w_pop),
    .o_wr_ptr (w_wr_ptr),
    .o_rd_ptr (w_rd_ptr),
    .o_count  (count_o),
    .o_full   (w_full),
    .o_empty  (w_empty)
  );

  // Storage is deliberately not reset; empty slots are never visible because
  // the output is masked whenever master_valid_o is low.
  always_ff @(posedge clk_i) begin
    if (w_wr_en) r_mem[w_wr_ptr] <= w_in_beat;
  end

  // Any accepted error beat latches the flag, bypassed beats included.
  always_ff @(posedge clk_i) begin
    if (rst_i)                                  r_resp_err <= 1'b0;
    else if (w_push && is_err_resp(slave_resp_i)) r_resp_err <= 1'b1;
  end

  assign resp_err_o   = r_resp_err;
  assign w_out_masked = master_valid_o ? w_out_beat : '0;
  assign {master_data_o, master_resp_o, master_last_o, master_user_o, master_id_o} = w_out_masked;

endmodule

// File: tb/tb_ext_r_buffer.sv
// Directed self-checking bench for ext_r_buffer (DEPTH=4 defaults).
// Inputs are driven 1 time unit after the rising edge and outputs sampled
// after a further settle delay, so nothing is sampled on the active edge.
module tb_ext_r_buffer;

`ifdef EXT_R_BUFFER_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        slave_valid_i = 1'b0;
  logic [63:0] slave_data_i = '0;
  logic [1:0]  slave_resp_i = '0;
  logic        slave_last_i = 1'b0;
  logic [3:0]  slave_id_i = '0;
  logic [5:0]  slave_user_i = '0;
  logic        slave_ready_o;
  logic        master_valid_o;
  logic [63:0] master_data_o;
  logic [1:0]  master_resp_o;
  logic        master_last_o;
  logic [3:0]  master_id_o;
  logic [5:0]  master_user_o;
  logic        master_ready_i = 1'b0;
  logic [2:0]  count_o;
  logic        resp_err_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  ext_r_buffer dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .slave_valid_i  (slave_valid_i),
    .slave_data_i   (slave_data_i),
    .slave_resp_i   (slave_resp_i),
    .slave_last_i   (slave_last_i),
    .slave_id_i     (slave_id_i),
    .slave_user_i   (slave_user_i),
    .slave_ready_o  (slave_ready_o),
    .master_valid_o (master_valid_o),
    .master_data_o  (master_data_o),
    .master_resp_o  (master_resp_o),
    .master_last_o  (master_last_o),
    .master_id_o    (master_id_o),
    .master_user_o  (master_user_o),
    .master_ready_i (master_ready_i),
    .count_o        (count_o),
    .resp_err_o     (resp_err_o)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic v, input logic [63:0] d, input logic [1:0] r,
                       input logic l, input logic [3:0] id);
    slave_valid_i = v;
    slave_data_i  = d;
    slave_resp_i  = r;
    slave_last_i  = l;
    slave_id_i    = id;
    slave_user_i  = 6'h2A;
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    drive(1'b1, 64'h99, 2'b00, 1'b0, 4'h1);
    tick();
    tick();
    n_checks++;
    if (master_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", master_valid_o); end
    n_checks++;
    if (slave_ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b want 0", slave_ready_o); end
    n_checks++;
    if (count_o !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", count_o); end
    n_checks++;
    if (master_data_o !== 64'h0) begin n_fail++; $display("FAIL reset_data got %h want 0", master_data_o); end
    drive(1'b0, 64'h0, 2'b00, 1'b0, 4'h0);
    rst_i = 1'b0;
    #1;
    n_checks++;
    if (slave_ready_o !== 1'b1) begin n_fail++; $display("FAIL post_reset_ready got %b want 1", slave_ready_o); end
    n_checks++;
    if (resp_err_o !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", resp_err_o); end
  endtask

  task automatic test_fill();
    master_ready_i = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 64'(i), 2'b00, 1'b0, 4'h3);
      tick();
    end
    n_checks++;
    if (count_o !== 3'd4) begin n_fail++; $display("FAIL fill_count got %0d want 4", count_o); end
    n_checks++;
    if (slave_ready_o !== 1'b0) begin n_fail++; $display("FAIL fill_ready got %b want 0", slave_ready_o); end
    // Fifth beat offered while full must be held off; head must stay stable.
    drive(1'b1, 64'h5, 2'b00, 1'b0, 4'h3);
    for (int c = 0; c < 2; c++) begin
      tick();
      n_checks++;
      if (count_o !== 3'd4) begin n_fail++; $display("FAIL fill_hold_count got %0d want 4", count_o); end
      n_checks++;
      if (master_valid_o !== 1'b1 || master_data_o !== 64'h1 || master_id_o !== 4'h3) begin
        n_fail++; $display("FAIL fill_head_stable got v=%b d=%h id=%h want v=1 d=1 id=3",
                           master_valid_o, master_data_o, master_id_o);
      end
    end
  endtask

  task automatic test_drain();
    drive(1'b0, 64'h0, 2'b00, 1'b0, 4'h0);
    master_ready_i = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (master_valid_o !== 1'b1 || master_data_o !== 64'(i + 1)) begin
        n_fail++; $display("FAIL drain_beat%0d got v=%b d=%h want v=1 d=%0d",
                           i, master_valid_o, master_data_o, i + 1);
      end
      tick();
      n_checks++;
      if (count_o !== 3'(3 - i)) begin n_fail++; $display("FAIL drain_count%0d got %0d want %0d", i, count_o, 3 - i); end
      n_checks++;
      if (slave_ready_o !== 1'b1) begin n_fail++; $display("FAIL drain_ready%0d got %b want 1", i, slave_ready_o); end
    end
    n_checks++;
    if (master_valid_o !== 1'b0 || master_data_o !== 64'h0) begin
      n_fail++; $display("FAIL drain_empty got v=%b d=%h want v=0 d=0", master_valid_o, master_data_o);
    end
  endtask

  task automatic test_stream();
    logic        expv;
    logic [63:0] expd;
    logic        expl;
    int          beat;
    master_ready_i = 1'b1;
    for (int k = 0; k <= 16; k++) begin
      if (k < 16) drive(1'b1, 64'h100 + 64'(k + 1), 2'b00, (k == 15), 4'h5);
      else        drive(1'b0, 64'h0, 2'b00, 1'b0, 4'h0);
      expv = BYP ? (k < 16) : (k >= 1);
      beat = BYP ? k + 1 : k;
      expd = expv ? 64'h100 + 64'(beat) : 64'h0;
      expl = expv && (beat == 16);
      n_checks++;
      if (master_valid_o !== expv || master_data_o !== expd || master_last_o !== expl) begin
        n_fail++; $display("FAIL stream_k%0d got v=%b d=%h l=%b want v=%b d=%h l=%b",
                           k, master_valid_o, master_data_o, master_last_o, expv, expd, expl);
      end
      n_checks++;
      if (count_o > 3'd1) begin n_fail++; $display("FAIL stream_count_k%0d got %0d want <=1", k, count_o); end
      tick();
    end
    n_checks++;
    if (count_o !== 3'd0) begin n_fail++; $display("FAIL stream_end_count got %0d want 0", count_o); end
  endtask

  task automatic test_err();
    master_ready_i = 1'b1;
    drive(1'b1, 64'h21, 2'b00, 1'b0, 4'h2);
    tick();
    n_checks++;
    if (resp_err_o !== 1'b0) begin n_fail++; $display("FAIL err_okay got %b want 0", resp_err_o); end
    drive(1'b1, 64'h22, 2'b10, 1'b0, 4'h2);
    tick();
    n_checks++;
    if (resp_err_o !== 1'b1) begin n_fail++; $display("FAIL err_set got %b want 1", resp_err_o); end
    drive(1'b1, 64'h23, 2'b00, 1'b1, 4'h2);
    tick();
    drive(1'b0, 64'h0, 2'b00, 1'b0, 4'h0);
    for (int c = 0; c < 3; c++) begin
      tick();
      n_checks++;
      if (resp_err_o !== 1'b1) begin n_fail++; $display("FAIL err_sticky%0d got %b want 1", c, resp_err_o); end
    end
  endtask

  task automatic test_reset_mid();
    master_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 64'h51 + 64'(i), 2'b00, 1'b0, 4'h7);
      tick();
    end
    drive(1'b0, 64'h0, 2'b00, 1'b0, 4'h0);
    n_checks++;
    if (count_o !== 3'd3) begin n_fail++; $display("FAIL mid_count got %0d want 3", count_o); end
    rst_i = 1'b1;
    #1;
    n_checks++;
    if (master_valid_o !== 1'b0 || slave_ready_o !== 1'b0) begin
      n_fail++; $display("FAIL mid_in_reset got v=%b rdy=%b want 0 0", master_valid_o, slave_ready_o);
    end
    tick();
    rst_i = 1'b0;
    master_ready_i = 1'b1;
    #1;
    n_checks++;
    if (count_o !== 3'd0 || master_valid_o !== 1'b0 || master_data_o !== 64'h0) begin
      n_fail++; $display("FAIL mid_after got cnt=%0d v=%b d=%h want 0 0 0", count_o, master_valid_o, master_data_o);
    end
    n_checks++;
    if (resp_err_o !== 1'b0) begin n_fail++; $display("FAIL mid_err_clear got %b want 0", resp_err_o); end
    for (int c = 0; c < 3; c++) begin
      tick();
      n_checks++;
      if (master_valid_o !== 1'b0) begin n_fail++; $display("FAIL mid_stale%0d got v=%b want 0", c, master_valid_o); end
    end
  endtask

`ifdef EXT_R_BUFFER_BYPASS_EN
  task automatic test_bypass();
    master_ready_i = 1'b1;
    drive(1'b1, 64'hAB, 2'b00, 1'b1, 4'h4);
    n_checks++;
    if (master_valid_o !== 1'b1 || master_data_o !== 64'hAB || count_o !== 3'd0) begin
      n_fail++; $display("FAIL bypass_same_cycle got v=%b d=%h cnt=%0d want 1 ab 0",
                         master_valid_o, master_data_o, count_o);
    end
    tick();
    drive(1'b0, 64'h0, 2'b00, 1'b0, 4'h0);
    n_checks++;
    if (count_o !== 3'd0) begin n_fail++; $display("FAIL bypass_count got %0d want 0", count_o); end
    master_ready_i = 1'b0;
    drive(1'b1, 64'hCD, 2'b00, 1'b0, 4'h4);
    tick();
    drive(1'b0, 64'h0, 2'b00, 1'b0, 4'h0);
    n_checks++;
    if (count_o !== 3'd1 || master_data_o !== 64'hCD) begin
      n_fail++; $display("FAIL bypass_stall got cnt=%0d d=%h want 1 cd", count_o, master_data_o);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_stream();
    test_err();
    test_reset_mid();
`ifdef EXT_R_BUFFER_BYPASS_EN
    test_bypass();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
